// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC output scheduler: record layout, marker byte,
// cycle-type encodings and serializer states.
package lpc_pkg;

    localparam int REC_W = 44;
    localparam logic [7:0] MARKER_DEFAULT = 8'hA5;

    localparam logic [3:0] CT_IO_RD  = 4'b0000;
    localparam logic [3:0] CT_IO_WR  = 4'b0010;
    localparam logic [3:0] CT_MEM_RD = 4'b0100;
    localparam logic [3:0] CT_MEM_WR = 4'b0110;

    // Record packing is {cyctype_dir, addr, data}, MSB first.
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = 8;
    localparam int CT_LSB   = 40;

    localparam logic [2:0] IDX_LAST = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/lpc_rec_fifo.sv
// Synchronous record FIFO with first-word-fall-through read data and a level count.
module lpc_rec_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lpc_out_scheduler.sv
// Filters decoded LPC records into a FIFO and serializes each one as a
// 7-byte frame (marker, cycle type, address MSB..LSB, data) on a valid/ready link.
module lpc_out_scheduler
    import lpc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] MARKER     = MARKER_DEFAULT
) (
    input  logic                          lpc_clock,
    input  logic                          lpc_reset,
    input  logic [3:0]                    in_cyctype_dir,
    input  logic [31:0]                   in_addr,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          filter_enable,
    input  logic [15:0]                   filter_base,
    input  logic [15:0]                   filter_mask,
    input  logic                          clear_status,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          overflow,
    output logic [7:0]                    dropped_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    ser_state_e       state_q;
    logic [2:0]       idx_q;
    logic [REC_W-1:0] hold_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             overflow_q, overflow_d;
    logic [7:0]       dcnt_q, dcnt_d;

    logic [REC_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             filter_hit, accept, last_ack, pop, push, drop;

    function automatic logic [7:0] rec_byte(input logic [2:0] idx, input logic [REC_W-1:0] rec);
        case (idx)
            3'd0:    return MARKER;
            3'd1:    return {4'h0, rec[CT_LSB +: 4]};
            3'd2:    return rec[ADDR_LSB+24 +: 8];
            3'd3:    return rec[ADDR_LSB+16 +: 8];
            3'd4:    return rec[ADDR_LSB+8 +: 8];
            3'd5:    return rec[ADDR_LSB +: 8];
            default: return rec[DATA_LSB +: 8];
        endcase
    endfunction

    // All decisions below use the pre-edge FIFO state, so a record arriving
    // this edge can never be popped on the same edge.
    assign filter_hit = !filter_enable ||
                        ((in_addr[15:0] & filter_mask) == (filter_base & filter_mask));
    assign accept     = in_valid && filter_hit;
    assign last_ack   = (state_q == S_SEND) && (idx_q == IDX_LAST) && tx_ready;
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || last_ack);
    assign drop       = accept && fifo_full && !pop;
    assign push       = accept && !drop;

    lpc_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (lpc_clock),
        .rst_ni  (lpc_reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_cyctype_dir, in_addr, in_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else if (pop) begin
            state_q    <= S_SEND;
            idx_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= MARKER;
        end else if (last_ack) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else if ((state_q == S_SEND) && tx_ready) begin
            idx_q     <= idx_q + 3'd1;
            tx_data_q <= rec_byte(idx_q + 3'd1, hold_q);
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (pop) hold_q <= fifo_rdata;
    end

    // A drop on the same edge as a clear wins, leaving exactly one counted drop.
    always_comb begin
        overflow_d = overflow_q;
        dcnt_d     = dcnt_q;
        if (clear_status) begin
            overflow_d = 1'b0;
            dcnt_d     = 8'h00;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (dcnt_d != 8'hFF) dcnt_d = dcnt_d + 8'h01;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            overflow_q <= 1'b0;
            dcnt_q     <= 8'h00;
        end else begin
            overflow_q <= overflow_d;
            dcnt_q     <= dcnt_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign overflow      = overflow_q;
    assign dropped_count = dcnt_q;

endmodule

// File: doc/lpc_out_scheduler.md
LPC_OUT_SCHEDULER -- requirements
Module: lpc_out_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: record FIFO depth in records, power of two, minimum 2.
REQ-002 Parameter MARKER, default 8'hA5: first byte of every serialized record.
REQ-003 Ports, in order:
- lpc_clock, input, 1 bit: the single clock; all logic on rising edge.
- lpc_reset, input, 1 bit: reset, asynchronous, active-low.
- in_cyctype_dir, input, 4 bits: decoded cycle type and direction.
- in_addr, input, 32 bits: decoded address.
- in_data, input, 8 bits: decoded data.
- in_valid, input, 1 bit: one-cycle strobe qualifying the in_* record.
- filter_enable, input, 1 bit: enables the address filter.
- filter_base, input, 16 bits: filter compare value.
- filter_mask, input, 16 bits: filter bit mask; 1 means the bit is compared.
- clear_status, input, 1 bit: synchronous clear of overflow and dropped_count.
- tx_data, output, 8 bits: serialized byte.
- tx_valid, output, 1 bit: tx_data is valid.
- tx_ready, input, 1 bit: sink accepts the byte.
- overflow, output, 1 bit: sticky flag, a record was dropped.
- dropped_count, output, 8 bits: saturating count of dropped records.
- fifo_level, output, log2(FIFO_DEPTH)+1 bits: records currently stored.

Function
REQ-004 A record {in_cyctype_dir, in_addr, in_data} (44 bits) is a candidate on every rising edge where in_valid=1.
REQ-005 Filter: with filter_enable=1, a candidate is accepted only if (in_addr[15:0] & filter_mask) == (filter_base & filter_mask); a filtered candidate is silently discarded and is not counted as a drop.
REQ-006 An accepted candidate is pushed on the same edge if the FIFO is not full, or if the FIFO is full and a pop occurs on that edge.
REQ-007 An accepted candidate arriving with the FIFO full and no pop is dropped: overflow is set to 1, and dropped_count increments, saturating at 255.
REQ-008 clear_status=1 clears overflow and dropped_count; if a drop occurs on the same edge, the result is overflow=1 and dropped_count=1.
REQ-009 Serializer FSM states: IDLE and SEND; a 3-bit byte index runs 0..6.
REQ-010 IDLE with FIFO non-empty: pop one record into the holding register, go to SEND, index=0.
REQ-011 SEND: tx_valid=1; tx_data by index:
- 0: MARKER
- 1: {4'h0, cyctype_dir}
- 2: addr[31:24]
- 3: addr[23:16]
- 4: addr[15:8]
- 5: addr[7:0]
- 6: data
REQ-012 In SEND, tx_valid & tx_ready advances the index.
REQ-013 In SEND at index 6 with tx_ready=1: if the FIFO is non-empty, pop and stay in SEND with index=0 (no idle gap); otherwise go to IDLE.
REQ-014 tx_data is held stable while tx_valid=1 and tx_ready=0; tx_valid never drops before acceptance.
REQ-015 Latency: on an idle, empty block, in_valid sampled at edge N produces tx_valid=1 with MARKER after edge N+1.
REQ-016 A candidate arriving at edge N is not visible to the pop at edge N; pop decisions use the pre-edge level only.
REQ-017 fifo_level reflects push and pop of the previous edge; simultaneous push and pop leaves the level unchanged.
REQ-018 In IDLE, tx_valid=0 and tx_data=8'h00.

Reset
REQ-019 lpc_reset=0 asynchronously forces: IDLE, index=0, FIFO empty, fifo_level=0, tx_valid=0, tx_data=8'h00, overflow=0, dropped_count=0.
REQ-020 Reset asserted mid-record discards the partial record and all FIFO contents; after release the first output byte is always MARKER.
REQ-021 In_valid on the first edge after reset release is processed normally.

Structure
REQ-022 Shared package lpc_pkg holds:
- record width constant (44)
- MARKER default
- cycle-type encodings (4'b0000 I/O read, 4'b0010 I/O write, 4'b0100 mem read, 4'b0110 mem write)
- record field offsets
REQ-023 The FIFO is a separate sub-module lpc_rec_fifo (parameterized width/depth, push/pop, full/empty/level, async active-low reset); the FSM, filter and status logic stay in lpc_out_scheduler.

Verification
REQ-024 Single I/O read record, ct_dir=0, addr=0x00007fe5, data=0x6c, tx_ready=1 -> bytes A5,00,00,00,7f,e5,6c on 7 consecutive cycles, then tx_valid=0.
REQ-025 Backpressure: same record, tx_ready toggling 1/0 -> identical byte sequence; tx_data stable during every stall cycle.
REQ-026 Filter: filter_enable=1, base=0x0080, mask=0xfff0; records addr 0x0084 and 0x7fe5 -> only the 0x0084 record is emitted; dropped_count=0.
REQ-027 Overflow: tx_ready=0, 10 records with FIFO_DEPTH=8 -> fifo_level=8, overflow=1, dropped_count=1 (one record held in SEND); then clear_status -> both 0.
REQ-028 Full with simultaneous pop and push -> push accepted, no drop, level unchanged; back-to-back records emitted with no gap.
REQ-029 lpc_reset pulsed low at index 3 -> all outputs at reset values; the next record emits starting with A5.
